sparc_ifu_thrsched: RTL
=======================

// Module: sparc_ifu_thrsched
// PURPOSE
//  Four-thread switch scheduler for the IFU. Watches the 5-bit state of four per-thread
//  FSMs and drives their schedule/switch_out inputs, so that at most one thread runs.
//  Picks round-robin, ready before spec-ready, and forces a switch when a time quantum
//  expires. Sits beside the fetch control logic and feeds the per-thread FSMs.
// PARAMETERS
//  QUANTUM  16  cycles a thread may run before a switch is forced (>=2, <=2**QW-1)
//  QW       5   width of the run-length counter
// PORTS
//  clk          in   1   core clock
//  reset        in   1   synchronous, active-high reset
//  thr_state    in   20  {t3,t2,t1,t0} FSM states, 5b each
//  fetch_stall  in   1   fetch cannot accept a switch this cycle
//  schedule     out  4   one-hot, combinational: switch thread i in this cycle
//  switch_out   out  4   one-hot, combinational: switch running thread i out this cycle
//  cur_thr      out  4   one-hot thread owned by the scheduler (registered)
//  cur_valid    out  1   cur_thr is meaningful (registered)
// BEHAVIOUR
//  State decode per thread i, from s=thr_state[5i+4:5i]:
//   rdy=s[4]&~s[1] (RDY 11001); srdy=s[4]&s[1] (SPEC_RDY 10011); run=s[2] (RUN/SPEC_RUN)
//  Pick (combinational): scan round-robin from last_sched+1 mod 4. The first rdy thread
//   wins. If no thread is rdy, the first srdy thread wins. pick_v=|{rdy,srdy}.
//   "Other candidate" = pick_v over all threads except cur_thr.
//  FSM states: IDLE, RUN, SWAP. Registers: fsm, cur_thr, cur_valid, last_sched(2b), cnt(QW).
//   IDLE: if pick_v & ~fetch_stall -> schedule[pick]=1, cur_thr<=pick, cur_valid<=1,
//         last_sched<=pick, cnt<=0, go RUN. Otherwise stay; no outputs.
//   RUN:  if ~run[cur] (thread stalled/sw_cond to WAIT, or never entered RUN)
//           -> cur_valid<=0, go IDLE; no switch_out. This check has top priority.
//         elif cnt>=QUANTUM-1 & other candidate & ~fetch_stall
//           -> switch_out[cur]=1, go SWAP.
//         else: cnt<=cnt+1 when ~fetch_stall, saturating at 2**QW-1.
//   SWAP: cur_valid<=0. If pick_v & ~fetch_stall -> act as IDLE scheduling (same cycle).
//         The switched-out thread is RDY by now and is a candidate, but round-robin
//         places it last. If no candidate, or fetch_stall -> go IDLE.
//  Schedule latency: schedule asserts in the decision cycle; the target FSM shows RUN on
//   the next cycle. The cycle after scheduling, RUN state checks that run[cur] is set.
//  Invariants: at most one bit set across schedule|switch_out. Never two threads in run.
//   schedule only to a thread that is rdy|srdy in that cycle.
//  fetch_stall blocks only schedule/switch_out and cnt increments. The ~run exit from RUN
//   still happens.
//  Quantum expiry with no other candidate: no switch; cnt stays saturated, and the switch
//   fires the first cycle another thread becomes ready.
//  Reset (any cycle, including mid-switch): fsm=IDLE, cur_thr=0, cur_valid=0, cnt=0,
//   last_sched=3 (thread 0 highest first). schedule=switch_out=0 during reset.
//  Illegal thread state codes decode as not rdy/srdy/run. No assertion is fired here.
// TESTING
//  1 t0..t3 all RDY after reset -> schedule=0001; t0 RUN next cycle; cur_thr=0001.
//  2 t0 RUN, t2 RDY, QUANTUM=16 -> switch_out=0001 on 16th RUN cycle; next cycle
//    schedule=0100.
//  3 t1 RUN, t1 goes WAIT while t3 RDY -> cur_valid=0, no switch_out; next cycle
//    schedule=1000.
//  4 t0 SPEC_RDY, t3 RDY, last_sched=0 -> schedule=1000 (ready beats spec-ready).
//  5 fetch_stall=1 at quantum expiry for 3 cycles -> no switch_out and cnt frozen;
//    switch_out on the first cycle with fetch_stall=0.
//  6 reset asserted in SWAP -> next cycle cur_valid=0, outputs 0; after release,
//    schedule picks thread 0 first.

Source files
------------

// File: rtl/sparc_ifu_thrsched.sv
// Four-thread switch scheduler: picks a thread round-robin (ready before spec-ready),
// drives the per-thread FSM schedule/switch_out strobes and forces a switch on quantum expiry.
module sparc_ifu_thrsched #(
  parameter int QUANTUM = 16,
  parameter int QW      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] thr_state,
  input  logic        fetch_stall,
  output logic [3:0]  schedule,
  output logic [3:0]  switch_out,
  output logic [3:0]  cur_thr,
  output logic        cur_valid
);

  typedef enum logic [1:0] {IDLE, RUN, SWAP} fsm_e;

  localparam logic [QW-1:0] QLIM = QW'(QUANTUM - 1);
  localparam logic [QW-1:0] CMAX = '1;

  fsm_e          fsm_q, fsm_d;
  logic [3:0]    cur_thr_q, cur_thr_d;
  logic          cur_valid_q, cur_valid_d;
  logic [1:0]    last_q, last_d;
  logic [QW-1:0] cnt_q, cnt_d;

  logic [3:0] rdy, srdy, run;
  logic [2:0] pick_rdy, pick_srdy;
  logic [1:0] pick_idx;
  logic       pick_v, other_cand, run_cur;
  logic       unused_bits;

  // Returns {any_set, first set index scanning upward from base, wrapping}.
  function automatic logic [2:0] rr_first(input logic [3:0] v, input logic [1:0] base);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    dbl = {v, v};
    rot = dbl[base +: 4];
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    return {|v, base + off};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdy[i]  = thr_state[5*i+4] & ~thr_state[5*i+1];
      srdy[i] = thr_state[5*i+4] &  thr_state[5*i+1];
      run[i]  = thr_state[5*i+2];
    end
  end

  assign unused_bits = ^{thr_state[18], thr_state[15], thr_state[13], thr_state[10],
                         thr_state[8], thr_state[5], thr_state[3], thr_state[0]};

  assign pick_rdy   = rr_first(rdy,  last_q + 2'd1);
  assign pick_srdy  = rr_first(srdy, last_q + 2'd1);
  assign pick_idx   = pick_rdy[2] ? pick_rdy[1:0] : pick_srdy[1:0];
  assign pick_v     = |(rdy | srdy);
  assign other_cand = |((rdy | srdy) & ~cur_thr_q);
  assign run_cur    = |(run & cur_thr_q);

  always_comb begin
    fsm_d       = fsm_q;
    cur_thr_d   = cur_thr_q;
    cur_valid_d = cur_valid_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    schedule    = 4'b0000;
    switch_out  = 4'b0000;
    case (fsm_q)
      IDLE, SWAP: begin
        if (pick_v && !fetch_stall) begin
          schedule    = 4'b0001 << pick_idx;
          cur_thr_d   = 4'b0001 << pick_idx;
          cur_valid_d = 1'b1;
          last_d      = pick_idx;
          cnt_d       = '0;
          fsm_d       = RUN;
        end else begin
          cur_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      RUN: begin
        // Losing RUN (stall to WAIT, or never entered) beats any quantum switch.
        if (!run_cur) begin
          cur_valid_d = 1'b0;
          fsm_d       = IDLE;
        end else if (cnt_q >= QLIM && other_cand && !fetch_stall) begin
          switch_out = cur_thr_q;
          fsm_d      = SWAP;
        end else if (!fetch_stall && cnt_q != CMAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
    if (reset) begin
      schedule   = 4'b0000;
      switch_out = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      cur_thr_q   <= 4'b0001;
      cur_valid_q <= 1'b0;
      last_q      <= 2'd3;
      cnt_q       <= '0;
    end else begin
      fsm_q       <= fsm_d;
      cur_thr_q   <= cur_thr_d;
      cur_valid_q <= cur_valid_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cur_thr   = cur_thr_q;
  assign cur_valid = cur_valid_q;

endmodule
